// File: rtl/conversion_pkg.sv
// Shared types and defaults for the conversion decoder.
package conversion_pkg;

  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } state_t;

  localparam int unsigned WORD_W_DEFAULT = 8;

endpackage

// File: rtl/conversion_bit_decoder.sv
// Two-state differential bit decoder: x follows z in S1, inverts it in S0;
// a decoded 0 toggles the state. x_c is the same-cycle decode for word assembly.
module conversion_bit_decoder
  import conversion_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic z_in,
  input  logic z_valid,
  input  logic sync,
  output logic x,
  output logic x_strobe,
  output logic x_c
);

  state_t state_q, state_d, state_base;
  logic   x_q, x_d;
  logic   x_strobe_q, x_strobe_d;

  // Sync restarts the frame in S1, and a bit arriving with it decodes from S1.
  always_comb begin
    state_base = sync ? S1 : state_q;
    x_c        = (state_base == S1) ? z_in : ~z_in;
    state_d    = state_base;
    x_d        = x_q;
    x_strobe_d = 1'b0;
    if (z_valid) begin
      x_d        = x_c;
      x_strobe_d = 1'b1;
      if (!x_c) begin
        state_d = (state_base == S1) ? S0 : S1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S1;
      x_q        <= 1'b0;
      x_strobe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      x_strobe_q <= x_strobe_d;
    end
  end

  assign x        = x_q;
  assign x_strobe = x_strobe_q;

endmodule

// File: rtl/conversion_decoder.sv
// Serial conversion decoder: decodes z, assembles LSB-first words, holds them for a
// valid/ready consumer. CONV_DEC_PARITY_EN adds a trailing even-parity bit and word_perr.
module conversion_decoder
  import conversion_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              z_in,
  input  logic              z_valid,
  input  logic              sync,
  output logic              x_out,
  output logic              x_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun
`ifdef CONV_DEC_PARITY_EN
  ,
  output logic              word_perr
`endif
);

`ifdef CONV_DEC_PARITY_EN
  localparam int unsigned FRAME_W = WORD_W + 1;
`else
  localparam int unsigned FRAME_W = WORD_W;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  logic               x_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [FRAME_W-1:0] sr_q, sr_d, sr_base, sr_next;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic               overrun_q, overrun_d;
  logic               perr_q, perr_d;
  logic               frame_done;

  conversion_bit_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .z_in     (z_in),
    .z_valid  (z_valid),
    .sync     (sync),
    .x        (x_out),
    .x_strobe (x_valid),
    .x_c      (x_c)
  );

  // Shifting in from the top leaves the first received bit at the LSB once a frame fills.
  always_comb begin
    cnt_base     = sync ? '0 : cnt_q;
    sr_base      = sync ? '0 : sr_q;
    sr_next      = {x_c, sr_base[FRAME_W-1:1]};
    cnt_d        = cnt_base;
    sr_d         = sr_base;
    frame_done   = 1'b0;
    word_d       = word_q;
    word_valid_d = word_valid_q && !word_ready;
    overrun_d    = overrun_q;
    perr_d       = perr_q;
    if (z_valid) begin
      frame_done = (cnt_base == CNT_LAST);
      cnt_d      = frame_done ? '0 : cnt_base + CNT_W'(1);
      sr_d       = frame_done ? '0 : sr_next;
    end
    // A finished frame loads only if the holding register is free or being emptied now.
    if (frame_done) begin
      if (!word_valid_q || word_ready) begin
        word_valid_d = 1'b1;
        word_d       = sr_next[WORD_W-1:0];
        perr_d       = ^sr_next;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      perr_q       <= perr_d;
    end
  end

  assign word_data  = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
`ifdef CONV_DEC_PARITY_EN
  assign word_perr  = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule

// File: doc/conversion_decoder.md
CONVERSION_DECODER -- requirements
Module: conversion_decoder

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning decoded bits per word (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port z_in  input  1  encoded serial bit.
REQ-005 SHALL have port z_valid  input  1  z_in is sampled this cycle.
REQ-006 SHALL have port sync  input  1  start-of-frame resynchronisation strobe.
REQ-007 SHALL have port x_out  output  1  decoded bit, registered.
REQ-008 SHALL have port x_valid  output  1  x_out valid, one-cycle pulse.
REQ-009 SHALL have port word_data  output  WORD_W  assembled word, LSB = first received bit.
REQ-010 SHALL have port word_valid  output  1  word_data valid, held until accepted.
REQ-011 SHALL have port word_ready  input  1  consumer accepts word when word_valid and word_ready are both high.
REQ-012 SHALL have port overrun  output  1  sticky flag for a dropped word.

Function
REQ-013 SHALL hold a 2-state decoder state {S0, S1}, reset to S1.
REQ-014 SHALL decode on a z_valid cycle as follows: in S1, x = z_in; in S0, x = ~z_in.
REQ-015 SHALL toggle the decoder state when the decoded x = 0 and SHALL hold it when x = 1; without z_valid the state is held.
REQ-016 SHALL present the decoded bit on x_out with x_valid = 1 in the cycle after the z_valid cycle (latency 1); x_out holds its last value otherwise.
REQ-017 SHALL shift decoded bits LSB-first into a shift register, tracking a bit counter 0..WORD_W-1 that wraps to 0 after the last bit.
REQ-018 SHALL load a completed word into the word_data holding register and assert word_valid in the cycle after the final bit's z_valid cycle.
REQ-019 SHALL keep word_data and word_valid stable while word_valid = 1 and word_ready = 0.
REQ-020 SHALL drop word_valid in the cycle after a handshake unless a new word completes in that same handshake cycle, in which case the new word loads and word_valid stays 1.
REQ-021 SHALL discard a word that completes while word_valid = 1 and word_ready = 0, keep the old word, and set overrun; overrun clears only on rst.
REQ-022 SHALL, on sync = 1, force the decoder state to S1 and clear the bit counter and shift register; the holding register, word_valid and overrun are unaffected.
REQ-023 SHALL, when sync and z_valid occur in the same cycle, decode that bit from S1 as bit 0 of the new frame.
REQ-024 SHALL leave any partial word uncounted and unflagged when sync discards it.

Reset
REQ-025 SHALL, while rst = 1, drive the decoder state to S1, the counter and shift register to 0, and x_out, x_valid, word_data, word_valid, overrun and word_perr to 0.
REQ-026 SHALL ignore z_valid, sync and word_ready in any cycle where rst = 1; rst mid-word discards the partial word.

Configuration
REQ-027 SHALL, with macro CONV_DEC_PARITY_EN defined, treat each frame as WORD_W data bits followed by 1 even-parity bit, and add output word_perr (1 bit, qualified by word_valid, high on parity mismatch).
REQ-028 SHALL keep the parity bit out of word_data while still passing it through the decoder state machine and x_out/x_valid.
REQ-029 SHALL, without CONV_DEC_PARITY_EN, omit the word_perr port and use WORD_W-bit frames.

Structure
REQ-030 SHALL import package conversion_pkg, which provides state_t enum {S0, S1} and the WORD_W default constant.
REQ-031 SHALL instantiate sub-module conversion_bit_decoder, containing the 2-state decoder with inputs z_in, z_valid and sync and outputs x and x_strobe; word assembly and handshake stay in the top level.

Verification
REQ-032 SHALL cover this scenario: after rst, z stream 1,0,0,1,0,0,1,1 with z_valid -> x_out sequence 1,0,1,0,0,1,0,1; word_data = 0xA5; word_valid 1 cycle after the 8th bit.
REQ-033 SHALL cover this scenario: z stream 1,1,1,1,1,1,1,1 -> 0xFF; z stream 0,1,0,1,0,1,0,1 -> 0x00; word_ready held high, so there is no overrun.
REQ-034 SHALL cover this scenario: word_ready held 0 while two full words arrive -> word_data keeps the first word, overrun = 1 and remains 1 after word_ready is asserted.
REQ-035 SHALL cover this scenario: sync after 3 bits, then the 0xA5 stream -> word_data = 0xA5, with no partial word emitted.
REQ-036 SHALL cover this scenario: rst pulsed mid-word, then the 0xA5 stream -> word_data = 0xA5 and all outputs are 0 during rst.
REQ-037 SHALL cover this scenario, with CONV_DEC_PARITY_EN: the 0xA5 stream plus encoded parity bit 0 (z = 0 from state S1) -> word_perr = 0; the same stream with parity z = 1 -> word_perr = 1.
